// File: rtl/findmax_pkg.sv
// Shared types and width helpers for the findmax arbiter slice.
//   state_t    : arbiter FSM states
//   clog2_min1 : ceil(log2(n)) but never below 1, for index/owner widths
package findmax_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/findmax_core.sv
// Running-max engine: tracks the largest unsigned sample seen since the last
// clear and the index it arrived at. The first sample after clr always loads;
// later samples replace the result only when strictly greater, so ties keep
// the earliest index.
// Ports:
//   CLK, RST_n   clock, async active-low reset
//   clr          restart the search (dominates en)
//   en           accept x/idx this cycle
//   x, idx       sample and its position in the burst
//   max, argmax  result including the sample being accepted this cycle
module findmax_core #(
    parameter int W    = 8,
    parameter int IDXW = 3
) (
    input  logic            CLK,
    input  logic            RST_n,
    input  logic            clr,
    input  logic            en,
    input  logic [W-1:0]    x,
    input  logic [IDXW-1:0] idx,
    output logic [W-1:0]    max,
    output logic [IDXW-1:0] argmax
);

    logic [W-1:0]    max_q;
    logic [IDXW-1:0] argmax_q;
    logic            loaded_q;

    // Outputs look through the accepting sample so the owner of this engine
    // can capture the final result on the same edge as the last sample.
    always_comb begin
        max    = max_q;
        argmax = argmax_q;
        if (en && (!loaded_q || (x > max_q))) begin
            max    = x;
            argmax = idx;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            max_q    <= '0;
            argmax_q <= '0;
            loaded_q <= 1'b0;
        end else if (clr) begin
            max_q    <= '0;
            argmax_q <= '0;
            loaded_q <= 1'b0;
        end else begin
            max_q    <= max;
            argmax_q <= argmax;
            if (en) begin
                loaded_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/findmax_arbiter.sv
// Round-robin front end for one shared findmax_core. A granted requester
// streams LEN samples; the result (max, argmax, owner) is registered with a
// one-cycle done_r pulse.
//
// state  | meaning
// S_IDLE | no grant; pick next requester cyclically from rr_ptr, clear core
// S_RUN  | gnt held; accept owner samples, abort if owner drops req
// S_DONE | one-cycle tail after the last sample; advance rr_ptr
//
// Ports:
//   CLK, RST_n   clock, async active-low reset
//   req          per-requester burst request (level)
//   x_flat       samples, requester i at [i*W +: W]
//   x_valid      per-requester sample valid
//   gnt          one-hot registered grant
//   busy         high in RUN or DONE
//   done_r       one-cycle pulse, result registers just updated
//   max_r, argmax_r, owner_r   result of the last completed burst
module findmax_arbiter
    import findmax_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int W    = 8,
    parameter int LEN  = 8,
    parameter int IDXW = clog2_min1(LEN),
    parameter int OWNW = clog2_min1(NREQ)
) (
    input  logic              CLK,
    input  logic              RST_n,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] x_flat,
    input  logic [NREQ-1:0]   x_valid,
    output logic [NREQ-1:0]   gnt,
    output logic              busy,
    output logic              done_r,
    output logic [W-1:0]      max_r,
    output logic [IDXW-1:0]   argmax_r,
    output logic [OWNW-1:0]   owner_r
);

    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(LEN - 1);
    localparam logic [OWNW-1:0] LAST_OWN = OWNW'(NREQ - 1);

    state_t          state, state_nxt;
    logic [OWNW-1:0] own, rr_ptr, own_next, sel;
    logic            found;
    logic [IDXW-1:0] count;
    logic [W-1:0]    sample;
    logic            accept, core_clr, core_en;
    logic [W-1:0]    core_max;
    logic [IDXW-1:0] core_argmax;

    // Cyclic scan from rr_ptr: walk downwards so the last hit written is the
    // nearest requester at or after the pointer.
    always_comb begin
        int j;
        found = 1'b0;
        sel   = '0;
        j     = 0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            j = int'(rr_ptr) + i;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (req[j]) begin
                found = 1'b1;
                sel   = OWNW'(j);
            end
        end
    end

    assign own_next = (own == LAST_OWN) ? '0 : own + 1'b1;
    assign sample   = x_flat[int'(own)*W +: W];
    // A sample arriving with the owner's req already low belongs to an aborted
    // burst and is dropped.
    assign accept   = (state == S_RUN) && gnt[own] && req[own] && x_valid[own];
    assign busy     = (state != S_IDLE);

    always_comb begin
        state_nxt = state;
        core_clr  = 1'b0;
        core_en   = 1'b0;
        case (state)
            S_IDLE: begin
                if (found) begin
                    state_nxt = S_RUN;
                    core_clr  = 1'b1;
                end
            end
            S_RUN: begin
                if (!req[own]) begin
                    state_nxt = S_IDLE;
                end else if (accept) begin
                    core_en = 1'b1;
                    if (count == LAST_IDX) begin
                        state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            state    <= S_IDLE;
            rr_ptr   <= '0;
            own      <= '0;
            count    <= '0;
            gnt      <= '0;
            done_r   <= 1'b0;
            max_r    <= '0;
            argmax_r <= '0;
            owner_r  <= '0;
        end else begin
            state  <= state_nxt;
            done_r <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gnt   <= NREQ'(1) << sel;
                        own   <= sel;
                        count <= '0;
                    end
                end
                S_RUN: begin
                    if (!req[own]) begin
                        gnt    <= '0;
                        rr_ptr <= own_next;
                    end else if (accept) begin
                        count <= count + 1'b1;
                        if (count == LAST_IDX) begin
                            gnt      <= '0;
                            done_r   <= 1'b1;
                            max_r    <= core_max;
                            argmax_r <= core_argmax;
                            owner_r  <= own;
                        end
                    end
                end
                S_DONE: begin
                    rr_ptr <= own_next;
                end
                default: ;
            endcase
        end
    end

    findmax_core #(
        .W    (W),
        .IDXW (IDXW)
    ) u_core (
        .CLK    (CLK),
        .RST_n  (RST_n),
        .clr    (core_clr),
        .en     (core_en),
        .x      (sample),
        .idx    (count),
        .max    (core_max),
        .argmax (core_argmax)
    );

endmodule

// File: tb/tb_findmax_arbiter.sv
module tb_findmax_arbiter;

    localparam int NREQ = 2;
    localparam int W    = 8;
    localparam int LEN  = 8;
    localparam int IDXW = 3;
    localparam int OWNW = 1;

    logic              CLK;
    logic              RST_n;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] x_flat;
    logic [NREQ-1:0]   x_valid;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done_r;
    logic [W-1:0]      max_r;
    logic [IDXW-1:0]   argmax_r;
    logic [OWNW-1:0]   owner_r;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int done_cnt = 0;
    int onehot_bad = 0;
    logic [W-1:0] smp [LEN];

    findmax_arbiter #(.NREQ(NREQ), .W(W), .LEN(LEN)) dut (
        .CLK      (CLK),
        .RST_n    (RST_n),
        .req      (req),
        .x_flat   (x_flat),
        .x_valid  (x_valid),
        .gnt      (gnt),
        .busy     (busy),
        .done_r   (done_r),
        .max_r    (max_r),
        .argmax_r (argmax_r),
        .owner_r  (owner_r)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    always @(negedge CLK) begin
        if (done_r === 1'b1) done_cnt++;
        if ($countones(gnt) > 1) onehot_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Waits for gnt[r], streams smp[] with an optional stall of stall_n cycles
    // before sample stall_at, and reports grant/done cycles.
    task automatic serve(input int r, input int stall_at, input int stall_n,
                         output int g_cyc, output int d_cyc,
                         output bit to, output bit pulse_ok);
        int n, guard, left;
        n = 0; guard = 0; left = stall_n;
        to = 1'b0; pulse_ok = 1'b0; g_cyc = 0; d_cyc = 0;
        while (gnt[r] !== 1'b1 && guard < 20) begin
            tick();
            guard++;
        end
        if (gnt[r] !== 1'b1) begin
            to = 1'b1;
            return;
        end
        g_cyc = cyc;
        while (n < LEN && guard < 200) begin
            if (n == stall_at && left > 0) begin
                x_valid[r] = 1'b0;
                left--;
            end else begin
                x_valid[r] = 1'b1;
                x_flat[r*W +: W] = smp[n];
                n++;
            end
            tick();
            guard++;
        end
        x_valid[r] = 1'b0;
        d_cyc = cyc;
        pulse_ok = (done_r === 1'b1);
        tick();
        pulse_ok = pulse_ok && (done_r === 1'b0);
    endtask

    task automatic test_reset();
        n_chk++;
        if ({gnt, busy, done_r, max_r, argmax_r, owner_r} !== '0)
            $display("FAIL reset_outputs: got gnt=%b busy=%b done=%b max=%0d arg=%0d own=%0d want all 0",
                     gnt, busy, done_r, max_r, argmax_r, owner_r);
        else n_pass++;
        repeat (2) @(posedge CLK);
        #3 RST_n = 1'b1;
        tick();
        n_chk++;
        if ({gnt, busy} !== '0) $display("FAIL reset_idle: got gnt=%b busy=%b want 0", gnt, busy);
        else n_pass++;
    endtask

    task automatic test_req0_basic(output int lat);
        int g, d, d0; bit to, p;
        d0 = done_cnt;
        smp = '{8'd9, 8'd8, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd1};
        req = 2'b01;
        serve(0, LEN, 0, g, d, to, p);
        req = 2'b00;
        lat = d - g;
        n_chk++; if (to) $display("FAIL t1_grant_timeout: no gnt[0] within bound"); else n_pass++;
        n_chk++; if (!p) $display("FAIL t1_done_pulse: done_r not a single-cycle pulse at last accept+1"); else n_pass++;
        n_chk++; if (done_cnt - d0 != 1) $display("FAIL t1_done_count: got %0d want 1", done_cnt - d0); else n_pass++;
        n_chk++; if (lat != LEN) $display("FAIL t1_latency: got %0d want %0d", lat, LEN); else n_pass++;
        n_chk++;
        if (max_r !== 8'd9 || argmax_r !== 3'd0 || owner_r !== 1'b0)
            $display("FAIL t1_result: got max=%0d arg=%0d own=%0d want 9 0 0", max_r, argmax_r, owner_r);
        else n_pass++;
    endtask

    task automatic test_req1_tie();
        int g, d; bit to, p;
        smp = '{8'd5, 8'd7, 8'd7, 8'd2, 8'd7, 8'd0, 8'd1, 8'd3};
        req = 2'b10;
        serve(1, LEN, 0, g, d, to, p);
        req = 2'b00;
        n_chk++; if (to || !p) $display("FAIL t2_handshake: timeout=%0d pulse_ok=%0d want 0 1", to, p); else n_pass++;
        n_chk++;
        if (max_r !== 8'd7 || argmax_r !== 3'd1 || owner_r !== 1'b1)
            $display("FAIL t2_result: got max=%0d arg=%0d own=%0d want 7 1 1", max_r, argmax_r, owner_r);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int g0, d0, g1, d1, ob; bit to0, to1, p0, p1;
        ob = onehot_bad;
        smp = '{8'd10, 8'd20, 8'd30, 8'd40, 8'd50, 8'd60, 8'd70, 8'd80};
        req = 2'b11;
        serve(0, LEN, 0, g0, d0, to0, p0);
        req[0] = 1'b0;
        n_chk++;
        if (to0 || max_r !== 8'd80 || argmax_r !== 3'd7 || owner_r !== 1'b0)
            $display("FAIL t3_first: timeout=%0d max=%0d arg=%0d own=%0d want 0 80 7 0", to0, max_r, argmax_r, owner_r);
        else n_pass++;
        smp = '{8'd3, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0};
        serve(1, LEN, 0, g1, d1, to1, p1);
        req = 2'b00;
        n_chk++;
        if (to1 || max_r !== 8'd3 || argmax_r !== 3'd0 || owner_r !== 1'b1)
            $display("FAIL t3_second: timeout=%0d max=%0d arg=%0d own=%0d want 0 3 0 1", to1, max_r, argmax_r, owner_r);
        else n_pass++;
        n_chk++; if (g1 - d0 != 2) $display("FAIL t3_turnaround: gnt[1] %0d cycles after done_r, want 2", g1 - d0); else n_pass++;
        n_chk++; if (d1 - d0 != LEN + 2) $display("FAIL t3_done_spacing: got %0d want %0d", d1 - d0, LEN + 2); else n_pass++;
        n_chk++; if (onehot_bad != ob) $display("FAIL t3_onehot: %0d cycles with >1 gnt bit, want 0", onehot_bad - ob); else n_pass++;
    endtask

    task automatic test_stall(input int base_lat);
        int g, d; bit to, p;
        smp = '{8'd9, 8'd8, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd1};
        req = 2'b01;
        serve(0, 4, 3, g, d, to, p);
        req = 2'b00;
        n_chk++; if (to || !p) $display("FAIL t4_handshake: timeout=%0d pulse_ok=%0d want 0 1", to, p); else n_pass++;
        n_chk++; if (d - g != base_lat + 3) $display("FAIL t4_latency: got %0d want %0d", d - g, base_lat + 3); else n_pass++;
        n_chk++;
        if (max_r !== 8'd9 || argmax_r !== 3'd0 || owner_r !== 1'b0)
            $display("FAIL t4_result: got max=%0d arg=%0d own=%0d want 9 0 0", max_r, argmax_r, owner_r);
        else n_pass++;
    endtask

    // Leaves req0 granted and in progress for the reset test that follows.
    task automatic test_abort();
        int guard, dc, c;
        dc = done_cnt;
        guard = 0;
        req = 2'b11;
        while (gnt[1] !== 1'b1 && guard < 20) begin tick(); guard++; end
        n_chk++; if (gnt !== 2'b10) $display("FAIL t5_rr_grant: got gnt=%b want 10", gnt); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            x_valid[1] = 1'b1;
            x_flat[W +: W] = 8'(200 + k);
            tick();
        end
        req[1] = 1'b0;
        x_flat[W +: W] = 8'd250;
        c = cyc;
        tick();
        x_valid[1] = 1'b0;
        n_chk++; if (gnt !== 2'b00) $display("FAIL t5_gnt_drop: got gnt=%b want 00", gnt); else n_pass++;
        tick();
        n_chk++;
        if (gnt !== 2'b01 || cyc - c != 2) $display("FAIL t5_regrant: got gnt=%b after %0d cycles want 01 after 2", gnt, cyc - c);
        else n_pass++;
        n_chk++; if (done_cnt != dc) $display("FAIL t5_no_done: got %0d pulses want 0", done_cnt - dc); else n_pass++;
        n_chk++;
        if (max_r !== 8'd9 || argmax_r !== 3'd0 || owner_r !== 1'b0)
            $display("FAIL t5_result_hold: got max=%0d arg=%0d own=%0d want 9 0 0", max_r, argmax_r, owner_r);
        else n_pass++;
    endtask

    task automatic test_mid_reset();
        int g, d; bit to, p;
        req = 2'b11;
        x_valid[0] = 1'b1;
        x_flat[0 +: W] = 8'd50;
        tick();
        tick();
        x_valid[0] = 1'b0;
        #3 RST_n = 1'b0;
        #1;
        n_chk++;
        if ({gnt, busy, done_r, max_r, argmax_r, owner_r} !== '0)
            $display("FAIL t6_async_reset: got gnt=%b busy=%b done=%b max=%0d arg=%0d own=%0d want all 0",
                     gnt, busy, done_r, max_r, argmax_r, owner_r);
        else n_pass++;
        repeat (2) @(posedge CLK);
        #3 RST_n = 1'b1;
        tick();
        smp = '{8'd9, 8'd8, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd1};
        serve(0, LEN, 0, g, d, to, p);
        req = 2'b00;
        n_chk++; if (to || !p) $display("FAIL t6_restart_req0: timeout=%0d pulse_ok=%0d want 0 1", to, p); else n_pass++;
        n_chk++;
        if (max_r !== 8'd9 || argmax_r !== 3'd0 || owner_r !== 1'b0)
            $display("FAIL t6_result: got max=%0d arg=%0d own=%0d want 9 0 0", max_r, argmax_r, owner_r);
        else n_pass++;
    endtask

    task automatic test_random();
        int r, o, st, sn, g, d, ea; bit to, p;
        logic [W-1:0] em;
        for (int it = 0; it < 8; it++) begin
            r = int'($urandom_range(0, 1));
            o = 1 - r;
            for (int k = 0; k < LEN; k++) smp[k] = 8'($urandom_range(0, 255));
            if (it % 2 == 1) smp[$urandom_range(4, LEN-1)] = smp[$urandom_range(0, 3)];
            st = int'($urandom_range(0, LEN-1));
            sn = int'($urandom_range(0, 3));
            em = smp[0];
            ea = 0;
            for (int k = 1; k < LEN; k++) if (smp[k] > em) begin em = smp[k]; ea = k; end
            x_valid[o] = 1'b1;
            x_flat[o*W +: W] = 8'hFF;
            req = 2'b00;
            req[r] = 1'b1;
            serve(r, st, sn, g, d, to, p);
            req = 2'b00;
            x_valid = 2'b00;
            n_chk++;
            if (to || !p || d - g != LEN + sn)
                $display("FAIL rnd%0d_timing: timeout=%0d pulse_ok=%0d lat=%0d want 0 1 %0d", it, to, p, d - g, LEN + sn);
            else n_pass++;
            n_chk++;
            if (max_r !== em || argmax_r !== IDXW'(ea) || owner_r !== OWNW'(r))
                $display("FAIL rnd%0d_result: got max=%0d arg=%0d own=%0d want %0d %0d %0d",
                         it, max_r, argmax_r, owner_r, em, ea, r);
            else n_pass++;
        end
    endtask

    initial begin
        int base_lat;
        RST_n   = 1'b0;
        req     = '0;
        x_flat  = '0;
        x_valid = '0;
        #2;
        test_reset();
        test_req0_basic(base_lat);
        test_req1_tie();
        test_back_to_back();
        test_stall(base_lat);
        test_abort();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
